fixedpoint_addsub_pipe: RTL and testbench

FIXEDPOINT_ADDSUB_PIPE -- requirements
Module: fixedpoint_addsub_pipe

---
 rtl/fixedpoint_addsub_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_fixedpoint_addsub_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixedpoint_addsub_pipe.sv
// ============================================================================
// fixedpoint_addsub_pipe
// ----------------------------------------------------------------------------
// Two-stage pipelined signed fixed-point adder/subtractor with a valid/ready
// handshake on both sides.
//
//   Stage 1 : both operands are sign-extended to a common integer width and
//             rescaled to WFO fraction bits. Extra fraction bits are
//             zero-padded. Surplus fraction bits are dropped with an
//             arithmetic shift, which rounds toward minus infinity. The op bit
//             and the beat valid are captured with them.
//   Stage 2 : the exact sum/difference is formed with one guard integer bit.
//             It is range-checked against WIO.WFO and registered together
//             with the overflow flag and out_valid.
//
// Both stages share one enable, en = !out_valid | out_ready. A stalled output
// therefore freezes the whole pipe. Bubbles are never squeezed out. With
// out_ready held high the pipe accepts and delivers one beat per cycle.
//
// Build option:
//   FXP_ADDSUB_SAT_EN  defined   -> an overflowing result is clamped to the
//                                   most positive or most negative WIO.WFO
//                                   value, following the sign of the exact
//                                   result.
//                      undefined -> the low WIO+WFO bits of the exact value
//                                   are delivered (wrap-around).
//   The overflow flag and ovf_sticky behave the same in both builds.
//
// Parameters:
//   WI1, WF1 : operand-1 integer bits (sign included) / fraction bits
//   WI2, WF2 : operand-2 integer bits (sign included) / fraction bits
//   WIO, WFO : result integer bits (sign included) / fraction bits
//
// Ports:
//   clk        in   single clock; all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set valid
//   in_ready   out  operands are accepted this cycle
//   op         in   0 = in1 + in2, 1 = in1 - in2
//   in1        in   signed operand 1, WI1.WF1
//   in2        in   signed operand 2, WI2.WF2
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   result     out  signed result, WIO.WFO
//   overflow   out  result did not fit WIO.WFO (qualified by out_valid)
//   ovf_sticky out  set by any overflowing result loaded into stage 2
//   ovf_clr    in   synchronous clear of ovf_sticky; a set in the same cycle
//                   takes priority
// ============================================================================
module fixedpoint_addsub_pipe #(
    parameter int WI1 = 4,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 4,
    parameter int WIO = ((WI1 > WI2) ? WI1 : WI2) + 1,
    parameter int WFO = (WF1 > WF2) ? WF1 : WF2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [WI1+WF1-1:0]     in1,
    input  logic [WI2+WF2-1:0]     in2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIO+WFO-1:0]     result,
    output logic                   overflow,
    output logic                   ovf_sticky,
    input  logic                   ovf_clr
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    // WIM is the common integer width used for the aligned operands.
    // WA is the width of an aligned operand.
    // WE is the width of the exact sum. It has one more integer bit than WA,
    // so that the sum of two extremes, or the negation of the most-negative
    // in2, is always representable.
    // WO is the output width.
    localparam int W1  = WI1 + WF1;
    localparam int W2  = WI2 + WF2;
    localparam int WIM = (WI1 > WI2) ? WI1 : WI2;
    localparam int WA  = WIM + WFO;
    localparam int WE  = WA + 1;
    localparam int WO  = WIO + WFO;

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                 v1_q,         v1_d;
    logic                 op1_q,        op1_d;
    logic signed [WA-1:0] a1_q,         a1_d;
    logic signed [WA-1:0] a2_q,         a2_d;

    logic                 out_valid_q,  out_valid_d;
    logic        [WO-1:0] result_q,     result_d;
    logic                 overflow_q,   overflow_d;
    logic                 ovf_sticky_q, ovf_sticky_d;

    logic                 en;

    // One shared enable: a stalled output freezes both stages.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------------
    // Stage-1 alignment. Each operand is sign-extended to WIM integer bits and
    // then brought to WFO fraction bits.
    // ------------------------------------------------------------------------
    logic signed [WA-1:0] in1_al;
    logic signed [WA-1:0] in2_al;

    generate
        if (WFO >= WF1) begin : g_in1_pad
            // Extend first, then shift in zero fraction bits.
            assign in1_al = WA'(signed'(in1)) <<< (WFO - WF1);
        end else begin : g_in1_drop
            // An arithmetic shift drops the surplus LSBs and rounds toward
            // minus infinity. Any top bits lost in the cast are only copies of
            // the sign bit.
            assign in1_al = WA'(signed'(in1) >>> (WF1 - WFO));
        end

        if (WFO >= WF2) begin : g_in2_pad
            assign in2_al = WA'(signed'(in2)) <<< (WFO - WF2);
        end else begin : g_in2_drop
            assign in2_al = WA'(signed'(in2) >>> (WF2 - WFO));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage-2 arithmetic on the registered, aligned operands
    // ------------------------------------------------------------------------
    logic signed [WE-1:0] x1_s2;
    logic signed [WE-1:0] x2_s2;
    logic signed [WE-1:0] sum_s2;
    logic        [WO-1:0] wrap_s2;
    logic        [WO-1:0] res_s2;
    logic                 ovf_s2;

    assign x1_s2  = {a1_q[WA-1], a1_q};
    assign x2_s2  = {a2_q[WA-1], a2_q};
    assign sum_s2 = op1_q ? (x1_s2 - x2_s2) : (x1_s2 + x2_s2);

    generate
        if (WO >= WE) begin : g_out_fits
            // The output is at least as wide as the exact value. It can never
            // overflow, and it is only sign-extended.
            assign ovf_s2  = 1'b0;
            assign wrap_s2 = WO'(sum_s2);
        end else begin : g_out_narrow
            // The value fits only if every bit from the MSB down to the output
            // sign bit holds the same value.
            logic [WE-WO:0] top_bits;
            assign top_bits = sum_s2[WE-1:WO-1];
            assign ovf_s2   = !((&top_bits) || (top_bits == '0));
            assign wrap_s2  = sum_s2[WO-1:0];
        end
    endgenerate

`ifdef FXP_ADDSUB_SAT_EN
    localparam logic [WO-1:0] MAX_POS = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] MIN_NEG = {1'b1, {(WO-1){1'b0}}};

    // Clamp toward the side indicated by the sign of the exact value.
    assign res_s2 = !ovf_s2      ? wrap_s2 :
                    sum_s2[WE-1] ? MIN_NEG : MAX_POS;
`else
    assign res_s2 = wrap_s2;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        v1_d         = v1_q;
        op1_d        = op1_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        overflow_d   = overflow_q;
        ovf_sticky_d = ovf_sticky_q;

        if (en) begin
            // Stage 1 takes whatever is offered. A bubble travels as v1=0.
            v1_d  = in_valid;
            op1_d = op;
            a1_d  = in1_al;
            a2_d  = in2_al;

            // Stage 2 advances in lockstep with stage 1.
            out_valid_d = v1_q;
            if (v1_q) begin
                result_d   = res_s2;
                overflow_d = ovf_s2;
            end else begin
                overflow_d = 1'b0;
            end
        end

        // An overflowing load has priority over a clear in the same cycle, so
        // that the event is never lost.
        if (en && v1_q && ovf_s2) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers. Reset drops any beats that are in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q         <= 1'b0;
            op1_q        <= 1'b0;
            a1_q         <= '0;
            a2_q         <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            v1_q         <= v1_d;
            op1_q        <= op1_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign overflow   = overflow_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fixedpoint_addsub_pipe.sv
// ============================================================================
// tb_fixedpoint_addsub_pipe
// ----------------------------------------------------------------------------
// Four configurations run side by side from shared handshake inputs:
//   u_a : defaults                    (4.4 +/- 4.4 -> 5.4)
//   u_b : WIO=4                       (4.4 +/- 4.4 -> 4.4, can overflow)
//   u_c : WF1=2, WF2=6, WFO=6         (4.2 +/- 4.6 -> 5.6)
//   u_d : WFO=2                       (4.4 +/- 4.4 -> 5.2, drops LSBs)
// Expected results come from an arithmetic model of the real-valued operation.
// Each delivered beat is scored against a per-instance FIFO of expectations.
// ============================================================================
module tb_fixedpoint_addsub_pipe;

    typedef struct {
        longint res;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        op;
    logic        ovf_clr;
    logic [7:0]  in1_ab, in2_ab;
    logic [5:0]  in1_c;
    logic [9:0]  in2_c;

    logic        in_ready_a, out_valid_a, overflow_a, ovf_sticky_a;
    logic [8:0]  result_a;
    logic        in_ready_b, out_valid_b, overflow_b, ovf_sticky_b;
    logic [7:0]  result_b;
    logic        in_ready_c, out_valid_c, overflow_c, ovf_sticky_c;
    logic [10:0] result_c;
    logic        in_ready_d, out_valid_d, overflow_d, ovf_sticky_d;
    logic [6:0]  result_d;

    fixedpoint_addsub_pipe u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .op(op), .in1(in1_ab), .in2(in2_ab), .out_valid(out_valid_a),
        .out_ready(out_ready), .result(result_a), .overflow(overflow_a),
        .ovf_sticky(ovf_sticky_a), .ovf_clr(ovf_clr)
    );

    fixedpoint_addsub_pipe #(.WIO(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .op(op), .in1(in1_ab), .in2(in2_ab), .out_valid(out_valid_b),
        .out_ready(out_ready), .result(result_b), .overflow(overflow_b),
        .ovf_sticky(ovf_sticky_b), .ovf_clr(ovf_clr)
    );

    fixedpoint_addsub_pipe #(.WF1(2), .WF2(6), .WFO(6)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .op(op), .in1(in1_c), .in2(in2_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .result(result_c), .overflow(overflow_c),
        .ovf_sticky(ovf_sticky_c), .ovf_clr(ovf_clr)
    );

    fixedpoint_addsub_pipe #(.WFO(2)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d),
        .op(op), .in1(in1_ab), .in2(in2_ab), .out_valid(out_valid_d),
        .out_ready(out_ready), .result(result_d), .overflow(overflow_d),
        .ovf_sticky(ovf_sticky_d), .ovf_clr(ovf_clr)
    );

`ifdef FXP_ADDSUB_SAT_EN
    localparam logic [7:0] D1_RES_B = 8'h7F;
`else
    localparam logic [7:0] D1_RES_B = 8'hFF;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q_a[$], q_b[$], q_c[$], q_d[$];
    bit          st_a, st_b, st_c, st_d;
    logic [63:0] hr_a, hr_b, hr_c, hr_d;
    bit          last_acc;
    bit          seen_ovf_b;

    // ------------------------------------------------------------------------
    // Checking and modelling
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns v * 2^(wfo-wf), rounded toward minus infinity.
    function automatic longint scale(input longint v, input int wf, input int wfo);
        longint d;
        longint q;
        if (wfo >= wf) return v * (longint'(1) <<< (wfo - wf));
        d = longint'(1) <<< (wf - wfo);
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    function automatic exp_t model(input longint s1, input longint s2, input bit sub,
                                   input int wf1, input int wf2, input int wfo, input int wio);
        exp_t   r;
        longint x1, x2, e, lo, hi, v;
        int     wo;
        x1 = scale(s1, wf1, wfo);
        x2 = scale(s2, wf2, wfo);
        e  = sub ? (x1 - x2) : (x1 + x2);
        wo = wio + wfo;
        hi = (longint'(1) <<< (wo - 1)) - 1;
        lo = -hi - 1;
        r.ovf = (e > hi) || (e < lo);
        v = e;
`ifdef FXP_ADDSUB_SAT_EN
        if (e > hi) v = hi;
        else if (e < lo) v = lo;
`endif
        r.res = v & ((longint'(1) <<< wo) - 1);
        return r;
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 3))
            0:       return 8'h7F;
            1:       return 8'h80;
            default: return 8'($urandom());
        endcase
    endfunction

    task automatic hold(input string name, input bit was, input logic [63:0] prev,
                        input logic v, input logic [63:0] cur);
        if (was) begin
            check({name, "_hold_valid"}, 64'(v), 64'd1);
            check({name, "_hold_result"}, cur, prev);
        end
    endtask

    task automatic score(input string name, input logic [63:0] res, input logic ovf,
                         input int pending, input exp_t e);
        check({name, "_pending"}, 64'(pending > 0), 64'd1);
        if (pending > 0) begin
            check({name, "_result"}, res, 64'(e.res));
            check({name, "_overflow"}, 64'(ovf), 64'(e.ovf));
            $display("beat %s result=0x%0h overflow=%0d", name, res, ovf);
        end
    endtask

    // Called at the falling edge. It sees the handshakes that complete on the
    // next rising edge.
    task automatic sample();
        exp_t   e;
        int     n;
        longint s1, s2, c1, c2;
        hold("a", st_a, hr_a, out_valid_a, 64'(result_a));
        hold("b", st_b, hr_b, out_valid_b, 64'(result_b));
        hold("c", st_c, hr_c, out_valid_c, 64'(result_c));
        hold("d", st_d, hr_d, out_valid_d, 64'(result_d));
        st_a = out_valid_a && !out_ready; hr_a = 64'(result_a);
        st_b = out_valid_b && !out_ready; hr_b = 64'(result_b);
        st_c = out_valid_c && !out_ready; hr_c = 64'(result_c);
        st_d = out_valid_d && !out_ready; hr_d = 64'(result_d);

        s1 = longint'($signed(in1_ab));
        s2 = longint'($signed(in2_ab));
        c1 = longint'($signed(in1_c));
        c2 = longint'($signed(in2_c));
        last_acc = in_valid && in_ready_a;
        if (in_valid && in_ready_a) q_a.push_back(model(s1, s2, op, 4, 4, 4, 5));
        if (in_valid && in_ready_b) q_b.push_back(model(s1, s2, op, 4, 4, 4, 4));
        if (in_valid && in_ready_c) q_c.push_back(model(c1, c2, op, 2, 6, 6, 5));
        if (in_valid && in_ready_d) q_d.push_back(model(s1, s2, op, 4, 4, 2, 5));

        if (out_valid_a && out_ready) begin
            e.res = 0; e.ovf = 0; n = q_a.size();
            if (n > 0) e = q_a.pop_front();
            score("a", 64'(result_a), overflow_a, n, e);
        end
        if (out_valid_b && out_ready) begin
            e.res = 0; e.ovf = 0; n = q_b.size();
            if (n > 0) e = q_b.pop_front();
            if (e.ovf) seen_ovf_b = 1'b1;
            score("b", 64'(result_b), overflow_b, n, e);
        end
        if (out_valid_c && out_ready) begin
            e.res = 0; e.ovf = 0; n = q_c.size();
            if (n > 0) e = q_c.pop_front();
            score("c", 64'(result_c), overflow_c, n, e);
        end
        if (out_valid_d && out_ready) begin
            e.res = 0; e.ovf = 0; n = q_d.size();
            if (n > 0) e = q_d.pop_front();
            score("d", 64'(result_d), overflow_d, n, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
        st_a = 0; st_b = 0; st_c = 0; st_d = 0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; ovf_clr = 1'b0;
        in1_ab = '0; in2_ab = '0; in1_c = '0; in2_c = '0;
        st_a = 0; st_b = 0; st_c = 0; st_d = 0;
        hr_a = '0; hr_b = '0; hr_c = '0; hr_d = '0;
        last_acc = 0; seen_ovf_b = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_result", 64'(result_a), 64'd0);
        check("rst_overflow", 64'(overflow_a), 64'd0);
        check("rst_sticky", 64'(ovf_sticky_b), 64'd0);
        check("rst_in_ready", 64'(in_ready_a), 64'd1);
        rst_n = 1'b1;
        step();
        step();

        // D1: 7.9375 - (-8) = 15.9375. It fits 5.4 and overflows 4.4.
        in_valid = 1'b1; op = 1'b1; in1_ab = 8'h7F; in2_ab = 8'h80;
        in1_c = 6'h05; in2_c = 10'h3FF;
        step();
        in_valid = 1'b0;
        check("lat_cycle1_valid", 64'(out_valid_a), 64'd0);
        step();
        check("lat_cycle2_valid", 64'(out_valid_a), 64'd1);
        check("d1_result_a", 64'(result_a), 64'h0FF);
        check("d1_overflow_a", 64'(overflow_a), 64'd0);
        check("d1_result_b", 64'(result_b), 64'(D1_RES_B));
        check("d1_overflow_b", 64'(overflow_b), 64'd1);
        check("d1_sticky_b", 64'(ovf_sticky_b), 64'd1);
        check("d1_sticky_a", 64'(ovf_sticky_a), 64'd0);

        // D2: 1.5 + 1/64 with mixed fraction widths
        in_valid = 1'b1; op = 1'b0; in1_ab = 8'h10; in2_ab = 8'h20;
        in1_c = 6'h06; in2_c = 10'h001;
        step();
        in_valid = 1'b0;
        step();
        check("d2_valid_c", 64'(out_valid_c), 64'd1);
        check("d2_result_c", 64'(result_c), 64'h061);
        check("d2_overflow_c", 64'(overflow_c), 64'd0);
        step();

        // Sticky flag: a clear with no overflow, then a clear that coincides
        // with an overflowing load
        check("sticky_before_clr", 64'(ovf_sticky_b), 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sticky_cleared", 64'(ovf_sticky_b), 64'd0);
        in_valid = 1'b1; op = 1'b1; in1_ab = 8'h7F; in2_ab = 8'h80;
        step();
        in_valid = 1'b0; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sticky_set_wins", 64'(ovf_sticky_b), 64'd1);
        step();
        check("sticky_kept", 64'(ovf_sticky_b), 64'd1);

        // Backpressure: two beats in the pipe, a third waiting at the input
        in_valid = 1'b1; op = 1'b0; in1_ab = 8'h11; in2_ab = 8'h22;
        step();
        in1_ab = 8'h33; in2_ab = 8'h44;
        step();
        out_ready = 1'b0; in1_ab = 8'h55; in2_ab = 8'hA6;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_in_ready", 64'(in_ready_a), 64'd0);
            check("stall_out_valid", 64'(out_valid_a), 64'd1);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("stall_drained_a", 64'(q_a.size()), 64'd0);

        // Reset with two beats in flight
        in_valid = 1'b1; in1_ab = 8'h01; in2_ab = 8'h02;
        step();
        in1_ab = 8'h03; in2_ab = 8'h04;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid_a), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_drop_valid_a", 64'(out_valid_a), 64'd0);
        check("rst_drop_valid_c", 64'(out_valid_c), 64'd0);
        check("rst_drop_sticky_b", 64'(ovf_sticky_b), 64'd0);
        flush();
        @(posedge clk);
        #1;
        check("rst_hold_in_ready", 64'(in_ready_a), 64'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_valid", 64'(out_valid_a), 64'd0);
        end
        seen_ovf_b = 1'b0;

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op       = 1'($urandom_range(0, 1));
                in1_ab   = pick8();
                in2_ab   = pick8();
                in1_c    = 6'($urandom());
                in2_c    = 10'($urandom());
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("rand_drained_a", 64'(q_a.size()), 64'd0);
        check("rand_drained_b", 64'(q_b.size()), 64'd0);
        check("rand_drained_c", 64'(q_c.size()), 64'd0);
        check("rand_drained_d", 64'(q_d.size()), 64'd0);
        check("rand_sticky_b", 64'(ovf_sticky_b), 64'(seen_ovf_b));
        check("rand_sticky_a", 64'(ovf_sticky_a), 64'd0);
        check("rand_sticky_c", 64'(ovf_sticky_c), 64'd0);
        check("rand_sticky_d", 64'(ovf_sticky_d), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
